axi_lite_sram_ctrl: RTL

- Parametrised successor to the core's AXI-lite SRAM slave. Internal word-array storage replaces DPI calls, so the block is self-contained.
- Read and write channels are fully independent.
- Read and write latency are configurable, fixed or LFSR-randomised, so the LSU and IFU bus masters can be stressed against variable-latency memory.
- Out-of-range accesses return SLVERR instead of silently aliasing.
- Sits behind the crossbar in place of the current SRAM slave.

---
 rtl/axi_lite_sram_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_sram_ctrl.sv
// AXI-lite SRAM slave with internal word storage, independent read/write channels,
// fixed or LFSR-randomised response latency and SLVERR on out-of-range accesses.
module axi_lite_sram_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int                RD_LAT      = 1,
  parameter int                WR_LAT      = 1,
  parameter bit                RAND_LAT    = 1'b0,
  parameter logic [7:0]        LFSR_SEED   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int MAX_LAT = ((RD_LAT > WR_LAT) ? RD_LAT : WR_LAT) + 7;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} wstate_e;

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) >> OFF_W;
  endfunction

  function automatic logic [CNT_W-1:0] lat_of(input int base, input logic [2:0] r);
    logic [CNT_W-1:0] l;
    l = CNT_W'(base);
    if (RAND_LAT) l = l + CNT_W'(r);
    return l;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [7:0]        lfsr_q, lfsr_d;

  rstate_e           rstate_q, rstate_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d, rlat;
  logic [ADDR_W-1:0] raddr_q, raddr_d, rd_addr, rword;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rd_load, r_ok;

  wstate_e           wstate_q, wstate_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d, wlat;
  logic [ADDR_W-1:0] waddr_q, waddr_d, wword;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_commit, w_ok;

  // x^8+x^6+x^5+x^4+1
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    raddr_d  = raddr_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_load  = 1'b0;
    rd_addr  = raddr_q;
    rlat     = lat_of(RD_LAT, lfsr_q[2:0]);
    case (rstate_q)
      R_IDLE: if (arvalid && arready_q) begin
        raddr_d = araddr;
        rd_addr = araddr;
        rcnt_d  = rlat - 1'b1;
        if (rlat == CNT_W'(1)) begin
          rstate_d = R_RESP;
          rd_load  = 1'b1;
        end else begin
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: if (rcnt_q == CNT_W'(1)) begin
        rstate_d = R_RESP;
        rd_load  = 1'b1;
      end else begin
        rcnt_d = rcnt_q - 1'b1;
      end
      R_RESP: if (rready) begin
        rstate_d = R_IDLE;
        rvalid_d = 1'b0;
      end
      default: rstate_d = R_IDLE;
    endcase
    rword = word_of(rd_addr);
    r_ok  = (rd_addr >= BASE_ADDR) && (rword < ADDR_W'(DEPTH_WORDS));
    if (rd_load) begin
      rvalid_d = 1'b1;
      rdata_d  = r_ok ? mem[rword[IDX_W-1:0]] : '0;
      rresp_d  = r_ok ? OKAY : SLVERR;
    end
    arready_d = (rstate_d == R_IDLE);
  end

  // AW and W may land in either order; *_d reflects a beat accepted this edge
  always_comb begin
    wstate_d  = wstate_q;
    wcnt_d    = wcnt_q;
    waddr_d   = waddr_q;
    wbuf_d    = wbuf_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_commit = 1'b0;
    wlat      = lat_of(WR_LAT, lfsr_q[2:0]);
    case (wstate_q)
      W_COLLECT: begin
        if (awvalid && awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = awaddr;
        end
        if (wvalid && wready_q) begin
          w_held_d = 1'b1;
          wbuf_d   = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) begin
          wcnt_d = wlat - 1'b1;
          if (wlat == CNT_W'(1)) begin
            wstate_d  = W_RESP;
            wr_commit = 1'b1;
          end else begin
            wstate_d = W_WAIT;
          end
        end
      end
      W_WAIT: if (wcnt_q == CNT_W'(1)) begin
        wstate_d  = W_RESP;
        wr_commit = 1'b1;
      end else begin
        wcnt_d = wcnt_q - 1'b1;
      end
      W_RESP: if (bready) begin
        wstate_d  = W_COLLECT;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
      default: wstate_d = W_COLLECT;
    endcase
    wword = word_of(waddr_d);
    w_ok  = (waddr_d >= BASE_ADDR) && (wword < ADDR_W'(DEPTH_WORDS));
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_ok ? OKAY : SLVERR;
    end
    awready_d = (wstate_d == W_COLLECT) && !aw_held_d;
    wready_d  = (wstate_d == W_COLLECT) && !w_held_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= LFSR_SEED;
      rstate_q  <= R_IDLE;
      rcnt_q    <= '0;
      raddr_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      wstate_q  <= W_COLLECT;
      wcnt_q    <= '0;
      waddr_q   <= '0;
      wbuf_q    <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      lfsr_q    <= lfsr_d;
      rstate_q  <= rstate_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wstate_q  <= wstate_d;
      wcnt_q    <= wcnt_d;
      waddr_q   <= waddr_d;
      wbuf_q    <= wbuf_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Storage is never reset; nonblocking update gives read-before-write on a shared edge
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit && w_ok) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb_d[b]) mem[wword[IDX_W-1:0]][8*b +: 8] <= wbuf_d[8*b +: 8];
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule
